uart_tx_frame_engine: RTL

//  Parametrised UART transmit engine: serialises DATA_WIDTH-bit words into frames (start, data LSB first,

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_par_gen.sv | 21 ++
 rtl/uart_tx_frame_engine.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame engine: FSM state encoding,
// parity sense constants and the parity helper used by uart_tx_par_gen.
package uart_tx_pkg;

    localparam int MAX_DATA_WIDTH = 9;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_STOP2  = 3'd5
    } tx_state_e;

    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] word,
                                         input logic                      par_typ);
        logic p;
        case (par_typ)
            PAR_EVEN: p = ^word;
            PAR_ODD:  p = ~(^word);
            default:  p = ^word;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_par_gen.sv
// Combinational parity bit for the latched transmit word; the word is
// zero-extended to the package maximum, which leaves its parity unchanged.
module uart_tx_par_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    logic [MAX_DATA_WIDTH-1:0] word_s;

    // Widen the word and evaluate the selected parity sense.
    always_comb begin
        word_s = MAX_DATA_WIDTH'(data);
        parity = calc_parity(word_s, par_typ);
    end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: start, DATA_WIDTH data bits LSB first, optional
// parity, 1 or 2 stop bits. Define UART_TX_SKID_EN for a one-entry holding register.
module uart_tx_frame_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   DATA_VALID,
    output logic                   READY,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   STOP2,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    output logic                   TX_OUT,
    output logic                   BUSY
);

    localparam logic [2:0] ST_IDLE   = S_IDLE;
    localparam logic [2:0] ST_START  = S_START;
    localparam logic [2:0] ST_DATA   = S_DATA;
    localparam logic [2:0] ST_PARITY = S_PARITY;
    localparam logic [2:0] ST_STOP   = S_STOP;
    localparam logic [2:0] ST_STOP2  = S_STOP2;

    localparam int              IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic [2:0]             state_r;
    logic [PRESC_WIDTH-1:0] presc_cnt_r;
    logic [PRESC_WIDTH-1:0] presc_last_r;
    logic [IDX_W-1:0]       bit_idx_r;
    logic [DATA_WIDTH-1:0]  shift_r;
    logic [DATA_WIDTH-1:0]  word_r;
    logic                   par_en_r;
    logic                   par_typ_r;
    logic                   stop2_r;
    logic                   tx_out_r;
    logic                   busy_r;

    logic                   ready_s;
    logic                   accept_s;
    logic                   load_s;
    logic                   bit_end_s;
    logic                   parity_s;
    logic [DATA_WIDTH-1:0]  src_data_s;
    logic                   src_par_en_s;
    logic                   src_par_typ_s;
    logic                   src_stop2_s;
    logic [PRESC_WIDTH-1:0] src_presc_s;
    logic [PRESC_WIDTH-1:0] src_last_s;

    assign accept_s  = DATA_VALID && ready_s;
    assign bit_end_s = (presc_cnt_r == presc_last_r);

`ifdef UART_TX_SKID_EN
    logic                   hold_full_r;
    logic [DATA_WIDTH-1:0]  hold_data_r;
    logic                   hold_par_en_r;
    logic                   hold_par_typ_r;
    logic                   hold_stop2_r;
    logic [PRESC_WIDTH-1:0] hold_presc_r;
    logic                   frame_end_s;

    assign ready_s     = !hold_full_r;
    assign frame_end_s = bit_end_s && (((state_r == ST_STOP) && !stop2_r) || (state_r == ST_STOP2));
    // A word arriving on the final stop cycle bypasses the holding register.
    assign load_s      = ((state_r == ST_IDLE) && accept_s) || (frame_end_s && (hold_full_r || accept_s));

    // Next-frame source: the held word has priority over the input port.
    always_comb begin
        if (hold_full_r) begin
            src_data_s    = hold_data_r;
            src_par_en_s  = hold_par_en_r;
            src_par_typ_s = hold_par_typ_r;
            src_stop2_s   = hold_stop2_r;
            src_presc_s   = hold_presc_r;
        end else begin
            src_data_s    = P_DATA;
            src_par_en_s  = PAR_EN;
            src_par_typ_s = PAR_TYP;
            src_stop2_s   = STOP2;
            src_presc_s   = PRESCALE;
        end
    end

    // Holding register: filled by a mid-frame accept, drained when the next frame loads.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_full_r    <= 1'b0;
            hold_data_r    <= '0;
            hold_par_en_r  <= 1'b0;
            hold_par_typ_r <= 1'b0;
            hold_stop2_r   <= 1'b0;
            hold_presc_r   <= '0;
        end else if (load_s && hold_full_r) begin
            hold_full_r <= 1'b0;
        end else if (accept_s && !load_s) begin
            hold_full_r    <= 1'b1;
            hold_data_r    <= P_DATA;
            hold_par_en_r  <= PAR_EN;
            hold_par_typ_r <= PAR_TYP;
            hold_stop2_r   <= STOP2;
            hold_presc_r   <= PRESCALE;
        end
    end
`else
    assign ready_s = (state_r == ST_IDLE);
    assign load_s  = accept_s;

    // Without a holding register the next frame always comes straight from the port.
    always_comb begin
        src_data_s    = P_DATA;
        src_par_en_s  = PAR_EN;
        src_par_typ_s = PAR_TYP;
        src_stop2_s   = STOP2;
        src_presc_s   = PRESCALE;
    end
`endif

    // A prescale of zero runs at one clock per bit.
    assign src_last_s = (src_presc_s == '0) ? '0 : (src_presc_s - PRESC_WIDTH'(1'b1));

    uart_tx_par_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par_gen (
        .data    (word_r),
        .par_typ (par_typ_r),
        .parity  (parity_s)
    );

    // Frame sequencer: bit timing, bit index, shifter and registered line/busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= ST_IDLE;
            presc_cnt_r  <= '0;
            presc_last_r <= '0;
            bit_idx_r    <= '0;
            shift_r      <= '0;
            word_r       <= '0;
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            stop2_r      <= 1'b0;
            tx_out_r     <= 1'b1;
            busy_r       <= 1'b0;
        end else if (load_s) begin
            state_r      <= ST_START;
            presc_cnt_r  <= '0;
            presc_last_r <= src_last_s;
            bit_idx_r    <= '0;
            shift_r      <= src_data_s;
            word_r       <= src_data_s;
            par_en_r     <= src_par_en_s;
            par_typ_r    <= src_par_typ_s;
            stop2_r      <= src_stop2_s;
            tx_out_r     <= 1'b0;
            busy_r       <= 1'b1;
        end else if (state_r != ST_IDLE) begin
            if (!bit_end_s) begin
                presc_cnt_r <= presc_cnt_r + PRESC_WIDTH'(1'b1);
            end else begin
                presc_cnt_r <= '0;
                case (state_r)
                    ST_START: begin
                        state_r  <= ST_DATA;
                        tx_out_r <= shift_r[0];
                    end
                    ST_DATA: begin
                        if (bit_idx_r == LAST_IDX) begin
                            state_r  <= par_en_r ? ST_PARITY : ST_STOP;
                            tx_out_r <= par_en_r ? parity_s : 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
                            shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                            tx_out_r  <= shift_r[1];
                        end
                    end
                    ST_PARITY: begin
                        state_r  <= ST_STOP;
                        tx_out_r <= 1'b1;
                    end
                    ST_STOP: begin
                        state_r  <= stop2_r ? ST_STOP2 : ST_IDLE;
                        tx_out_r <= 1'b1;
                        busy_r   <= stop2_r;
                    end
                    ST_STOP2: begin
                        state_r  <= ST_IDLE;
                        tx_out_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        tx_out_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign READY  = ready_s;
    assign TX_OUT = tx_out_r;
    assign BUSY   = busy_r;

endmodule
